floor_request_manager: RTL and testbench
========================================

# floor_request_manager

Request-side companion to the direction scoring logic: latches cab destination and hall call button presses into the per-elevator `FloorDestinations` / `FloorsRequested` vectors, and consumes the returned `elevatorPositions`. When an elevator reaches a whole floor with a pending request, the block stops it, runs the door dwell/close sequence, and clears the served request bits. It sits between the button I/O and the direction scoring system and closes the request/position loop.

## Interface

- `FLOORS`, 6: floors per elevator; vectors are 2×FLOORS bits wide.
- `DWELL_CYCLES`, 8: cycles the door stays open, ≥1.
- `CLOSE_CYCLES`, 4: cycles spent closing, ≥1.

- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `CabPress`  in  2×FLOORS  one-cycle-or-longer cab button pulses; bits 0..FLOORS-1 left elevator, FLOORS..2F-1 right
- `HallPress`  in  2×FLOORS  hall call pulses, same bit mapping
- `elevatorPositions`  in  8  [7:4] left, [3:0] right; half-floor encoding, value 2·f = at floor f, odd = between floors
- `FloorDestinations`  out  2×FLOORS  latched cab requests
- `FloorsRequested`  out  2×FLOORS  latched hall requests
- `StopHold`  out  2  [1] left, [0] right; scoring system must not move that elevator while high
- `DoorOpen`  out  2  door fully open indicator per elevator

## Operation

- Press latching: bit set on the cycle after any press bit is high; stays set until served. Repeated presses have no further effect.
- Per-elevator FSM, states TRACK, DOOR_OPEN, DOOR_CLOSE.
  - `at_floor` = position even and position/2 < FLOORS; otherwise not at a floor (no stop, no error).
  - `pending` = destination or request bit of the current floor set.
  - TRACK: if at_floor && pending → DOOR_OPEN, load dwell counter, clear both bits of that floor.
  - DOOR_OPEN: count down DWELL_CYCLES → DOOR_CLOSE, load close counter.
  - DOOR_CLOSE: count down CLOSE_CYCLES → TRACK.
- `StopHold[e]` combinational: (state≠TRACK) | (TRACK & at_floor & pending). `DoorOpen[e]` = state==DOOR_OPEN (registered).
- Press for the current floor while that elevator is in DOOR_OPEN: absorbed, bit stays 0 (see Configuration for dwell extension).
- Press for the current floor during DOOR_CLOSE: latched normally; on return to TRACK the elevator stops again at the same floor.
- Press for the current floor on the same cycle the TRACK→DOOR_OPEN clear occurs: clear wins, bit stays 0.
- Elevators fully independent; simultaneous stops on both sides are legal.
- Counters sized $clog2(max(DWELL_CYCLES,CLOSE_CYCLES)+1); no wrap possible.

## Timing

- Reset: all request bits 0, both FSMs TRACK, counters 0, `DoorOpen`=0; `StopHold` therefore equals 0 until a press latches.
- Reset asserted mid-sequence aborts it next edge; doors report closed, requests lost.
- Press at cycle N → bit visible at N+1.
- Position matches a pending floor at cycle N: `StopHold` high at N (combinational); bits cleared and `DoorOpen` high from N+1 through N+DWELL_CYCLES; DOOR_CLOSE N+DWELL+1 .. N+DWELL+CLOSE; TRACK again at N+DWELL+CLOSE+1, `StopHold` low then unless another request is pending.

## Configuration

- `DOOR_REOPEN_EN` defined: a press (cab or hall) for the current floor during DOOR_OPEN reloads the dwell counter to DWELL_CYCLES; during DOOR_CLOSE it returns the FSM to DOOR_OPEN with a full dwell instead of latching the bit.
- Undefined: behaviour exactly as in Operation (absorb in DOOR_OPEN, latch in DOOR_CLOSE).

## Structure

- Shared package `elevator_pkg`: NUM_ELEVATORS=2, POS_W=4, `door_state_e` enum {TRACK, DOOR_OPEN, DOOR_CLOSE}, function `pos_to_floor` returning floor index plus at_floor flag.
- One sub-module `elevator_door_fsm`, instantiated twice: takes at_floor, pending, same-floor press; produces clear pulse, StopHold, DoorOpen. The request registers stay in the top level.

## Test plan

- Reset then idle, positions 0x00 → all outputs 0 for 20 cycles.
- CabPress[3] pulse, left position 0x60 (floor 3) → bit 3 set next cycle, StopHold[1]=1 same cycle, DoorOpen[1]=1 for 8 cycles, bit 3 cleared, TRACK after 12 cycles.
- HallPress[8] with right position 0x5 (odd) → bit latched, no stop; position 0x4 → stop and clear of bit 8.
- Press floor 3 during DOOR_OPEN at floor 3 → without macro bit stays 0 and dwell unchanged; with `DOOR_REOPEN_EN` dwell restarts at 8.
- Both elevators reach pending floors same cycle → both StopHold bits high, independent sequences, both bits cleared.
- `rst` asserted in DOOR_OPEN with other bits pending → all bits 0, DoorOpen 0, StopHold 0 next cycle.

Source files
------------

// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared types and helpers for the elevator request/door logic
// Contents:
//   NUM_ELEVATORS, POS_W   elevator count and half-floor position width
//   door_state_e           per-elevator door sequencing states
//   floor_info_t           decoded position (floor index + at_floor flag)
//   pos_to_floor()         half-floor position -> floor_info_t
package elevator_pkg;

    localparam int NUM_ELEVATORS = 2;
    localparam int POS_W         = 4;

    typedef enum logic [1:0] {
        TRACK      = 2'd0,
        DOOR_OPEN  = 2'd1,
        DOOR_CLOSE = 2'd2
    } door_state_e;

    typedef struct packed {
        logic             at_floor;
        logic [POS_W-2:0] floor;
    } floor_info_t;

    // Even position 2*f means "at floor f"; odd positions are between floors.
    // Floors beyond the shaft height are treated as "not at a floor".
    function automatic floor_info_t pos_to_floor(input logic [POS_W-1:0] pos,
                                                 input int floors);
        floor_info_t info;
        info.floor    = pos[POS_W-1:1];
        info.at_floor = !pos[0] && (int'(info.floor) < floors);
        return info;
    endfunction

endpackage

// File: rtl/elevator_door_fsm.sv
// rtl/elevator_door_fsm.sv - per-elevator stop / door dwell / door close sequencer
// Optional feature macro: DOOR_REOPEN_EN (same-floor press reopens / extends the door)
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_at_floor      elevator sits exactly on a valid floor
//   i_pending       a cab or hall request exists for that floor
//   i_press         cab or hall press for that floor this cycle
//   o_clear         pulse: clear both request bits of the current floor
//   o_drop_press    the same-floor press must not be latched
//   o_stop_hold     scoring logic must keep this elevator still
//   o_door_open     door fully open (registered)
module elevator_door_fsm
    import elevator_pkg::*;
#(
    parameter int DWELL_CYCLES = 8,
    parameter int CLOSE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_at_floor,
    input  logic i_pending,
    input  logic i_press,
    output logic o_clear,
    output logic o_drop_press,
    output logic o_stop_hold,
    output logic o_door_open
);

    localparam int CNT_MAX = (DWELL_CYCLES > CLOSE_CYCLES) ? DWELL_CYCLES : CLOSE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] CLOSE_LOAD = CNT_W'(CLOSE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(1);

    door_state_e      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_door_open;
    logic             w_stop;

    assign w_stop       = i_at_floor & i_pending;
    assign o_clear      = (r_state == TRACK) & w_stop;
    // Hold asserts combinationally on the arrival cycle so the car never overshoots.
    assign o_stop_hold  = (r_state != TRACK) | o_clear;
    assign o_door_open  = r_door_open;

`ifdef DOOR_REOPEN_EN
    // Any same-floor press while stopped is turned into a door (re)open instead.
    assign o_drop_press = i_press & (r_state != TRACK);
`else
    // Only an open door absorbs the press; during closing it latches and re-stops later.
    assign o_drop_press = i_press & (r_state == DOOR_OPEN);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= TRACK;
            r_cnt       <= '0;
            r_door_open <= 1'b0;
        end else begin
            case (r_state)
                TRACK: begin
                    if (w_stop) begin
                        r_state     <= DOOR_OPEN;
                        r_cnt       <= DWELL_LOAD;
                        r_door_open <= 1'b1;
                    end
                end
                DOOR_OPEN: begin
`ifdef DOOR_REOPEN_EN
                    if (i_press) begin
                        r_cnt <= DWELL_LOAD;
                    end else
`endif
                    if (r_cnt == CNT_LAST) begin
                        r_state     <= DOOR_CLOSE;
                        r_cnt       <= CLOSE_LOAD;
                        r_door_open <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DOOR_CLOSE: begin
`ifdef DOOR_REOPEN_EN
                    if (i_press) begin
                        r_state     <= DOOR_OPEN;
                        r_cnt       <= DWELL_LOAD;
                        r_door_open <= 1'b1;
                    end else
`endif
                    if (r_cnt == CNT_LAST) begin
                        r_state <= TRACK;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state     <= TRACK;
                    r_cnt       <= '0;
                    r_door_open <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/floor_request_manager.sv
// rtl/floor_request_manager.sv - latches cab/hall requests and sequences floor stops for two elevators
// Optional feature macro: DOOR_REOPEN_EN (forwarded to elevator_door_fsm)
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   CabPress            cab button pulses, [F-1:0] left, [2F-1:F] right
//   HallPress           hall call pulses, same mapping
//   elevatorPositions   half-floor positions, [7:4] left, [3:0] right
//   FloorDestinations   latched cab requests
//   FloorsRequested     latched hall requests
//   StopHold            [1] left, [0] right: elevator must not move
//   DoorOpen            [1] left, [0] right: door fully open
module floor_request_manager
    import elevator_pkg::*;
#(
    parameter int FLOORS       = 6,
    parameter int DWELL_CYCLES = 8,
    parameter int CLOSE_CYCLES = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_ELEVATORS*FLOORS-1:0]     CabPress,
    input  logic [NUM_ELEVATORS*FLOORS-1:0]     HallPress,
    input  logic [NUM_ELEVATORS*POS_W-1:0]      elevatorPositions,
    output logic [NUM_ELEVATORS*FLOORS-1:0]     FloorDestinations,
    output logic [NUM_ELEVATORS*FLOORS-1:0]     FloorsRequested,
    output logic [NUM_ELEVATORS-1:0]            StopHold,
    output logic [NUM_ELEVATORS-1:0]            DoorOpen
);

    localparam int REQ_W = NUM_ELEVATORS * FLOORS;

    logic [REQ_W-1:0] r_dest;
    logic [REQ_W-1:0] r_req;
    logic [REQ_W-1:0] w_kill;

    // Elevator index e uses position slice e and request slice (NUM_ELEVATORS-1-e),
    // so index 1 is the left car (low request bits, high position nibble).
    for (genvar e = 0; e < NUM_ELEVATORS; e++) begin : g_elev
        localparam int BASE = (NUM_ELEVATORS - 1 - e) * FLOORS;

        floor_info_t       w_info;
        logic [FLOORS-1:0] w_hot;
        logic              w_pending;
        logic              w_press;
        logic              w_clear;
        logic              w_drop;

        assign w_info = pos_to_floor(elevatorPositions[e*POS_W +: POS_W], FLOORS);

        for (genvar f = 0; f < FLOORS; f++) begin : g_floor
            localparam logic [POS_W-2:0] FLOOR_IDX = (POS_W-1)'(f);
            assign w_hot[f] = w_info.at_floor && (w_info.floor == FLOOR_IDX);
        end

        assign w_pending = |((r_dest[BASE +: FLOORS] | r_req[BASE +: FLOORS]) & w_hot);
        assign w_press   = |((CabPress[BASE +: FLOORS] | HallPress[BASE +: FLOORS]) & w_hot);

        // Clearing on the stop cycle also swallows a same-cycle press for that floor.
        assign w_kill[BASE +: FLOORS] = w_hot & {FLOORS{w_clear | w_drop}};

        elevator_door_fsm #(
            .DWELL_CYCLES (DWELL_CYCLES),
            .CLOSE_CYCLES (CLOSE_CYCLES)
        ) u_door_fsm (
            .clk          (clk),
            .rst          (rst),
            .i_at_floor   (w_info.at_floor),
            .i_pending    (w_pending),
            .i_press      (w_press),
            .o_clear      (w_clear),
            .o_drop_press (w_drop),
            .o_stop_hold  (StopHold[e]),
            .o_door_open  (DoorOpen[e])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dest <= '0;
            r_req  <= '0;
        end else begin
            r_dest <= (r_dest | CabPress)  & ~w_kill;
            r_req  <= (r_req  | HallPress) & ~w_kill;
        end
    end

    assign FloorDestinations = r_dest;
    assign FloorsRequested   = r_req;

endmodule

// File: tb/tb_floor_request_manager.sv
// tb/tb_floor_request_manager.sv - self-checking bench for floor_request_manager
module tb_floor_request_manager;

`ifdef DOOR_REOPEN_EN
    localparam bit REOPEN = 1'b1;
`else
    localparam bit REOPEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] cab = '0;
    logic [11:0] hall = '0;
    logic [7:0]  pos = '0;
    logic [11:0] dest_o;
    logic [11:0] req_o;
    logic [1:0]  hold_o;
    logic [1:0]  door_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected {dest, req, StopHold, DoorOpen} per cycle.
    logic [27:0] sb_q[$];

    floor_request_manager #(
        .FLOORS       (6),
        .DWELL_CYCLES (8),
        .CLOSE_CYCLES (4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .CabPress          (cab),
        .HallPress         (hall),
        .elevatorPositions (pos),
        .FloorDestinations (dest_o),
        .FloorsRequested   (req_o),
        .StopHold          (hold_o),
        .DoorOpen          (door_o)
    );

    always #5 clk = ~clk;

    // Apply one cycle of stimulus away from the rising edge and queue its expectation.
    task automatic drive(input logic r, input logic [11:0] c, input logic [11:0] h,
                         input logic [7:0] p, input logic [27:0] e);
        @(negedge clk);
        rst  = r;
        cab  = c;
        hall = h;
        pos  = p;
        sb_q.push_back(e);
        #1;
    endtask

    function automatic logic [27:0] ex(input logic [11:0] d, input logic [11:0] q,
                                       input logic [1:0] s, input logic [1:0] o);
        return {d, q, s, o};
    endfunction

    task automatic test_reset();
        logic [27:0] exp_v;
        logic [27:0] got;
        for (int i = 0; i < 22; i++) begin
            drive((i < 2), 12'h000, 12'h000, 8'h00, ex(12'h000, 12'h000, 2'b00, 2'b00));
            exp_v = sb_q.pop_front();
            if (i >= 2) begin
                got = {dest_o, req_o, hold_o, door_o};
                n_tests++;
                if (got !== exp_v) begin
                    n_fail++;
                    $display("FAIL reset_idle c%0d: got %h expected %h", i, got, exp_v);
                end
            end
        end
    endtask

    task automatic test_cab_left();
        logic [27:0] exp_v;
        logic [27:0] got;
        for (int i = 0; i < 17; i++) begin
            drive(1'b0, (i == 0) ? 12'h008 : 12'h000, 12'h000, 8'h61,
                  ex((i == 1) ? 12'h008 : 12'h000, 12'h000,
                     {(i >= 1 && i <= 13), 1'b0}, {(i >= 2 && i <= 9), 1'b0}));
            exp_v = sb_q.pop_front();
            got   = {dest_o, req_o, hold_o, door_o};
            n_tests++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL cab_left c%0d: got %h expected %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_hall_right();
        logic [27:0] exp_v;
        logic [27:0] got;
        for (int i = 0; i < 18; i++) begin
            drive(1'b0, 12'h000, (i == 0) ? 12'h100 : 12'h000, (i < 3) ? 8'h15 : 8'h14,
                  ex(12'h000, (i >= 1 && i <= 3) ? 12'h100 : 12'h000,
                     {1'b0, (i >= 3 && i <= 15)}, {1'b0, (i >= 4 && i <= 11)}));
            exp_v = sb_q.pop_front();
            got   = {dest_o, req_o, hold_o, door_o};
            n_tests++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL hall_right c%0d: got %h expected %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_press_during_open();
        logic [27:0] exp_v;
        logic [27:0] got;
        int open_end;
        open_end = REOPEN ? 12 : 9;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, (i == 0 || i == 4) ? 12'h008 : 12'h000, 12'h000, 8'h61,
                  ex((i == 1) ? 12'h008 : 12'h000, 12'h000,
                     {(i >= 1 && i <= open_end + 4), 1'b0},
                     {(i >= 2 && i <= open_end), 1'b0}));
            exp_v = sb_q.pop_front();
            got   = {dest_o, req_o, hold_o, door_o};
            n_tests++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL press_open c%0d: got %h expected %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_press_during_close();
        logic [27:0] exp_v;
        logic [27:0] got;
        logic        d_on;
        logic        h_on;
        logic        o_on;
        for (int i = 0; i < 30; i++) begin
            if (REOPEN) begin
                d_on = (i == 1);
                h_on = (i >= 1 && i <= 23);
                o_on = (i >= 2 && i <= 9) || (i >= 12 && i <= 19);
            end else begin
                d_on = (i == 1) || (i >= 12 && i <= 14);
                h_on = (i >= 1 && i <= 26);
                o_on = (i >= 2 && i <= 9) || (i >= 15 && i <= 22);
            end
            drive(1'b0, (i == 0 || i == 11) ? 12'h008 : 12'h000, 12'h000, 8'h61,
                  ex(d_on ? 12'h008 : 12'h000, 12'h000, {h_on, 1'b0}, {o_on, 1'b0}));
            exp_v = sb_q.pop_front();
            got   = {dest_o, req_o, hold_o, door_o};
            n_tests++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL press_close c%0d: got %h expected %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_both_and_same_cycle_press();
        logic [27:0] exp_v;
        logic [27:0] got;
        logic [11:0] h;
        for (int i = 0; i < 17; i++) begin
            h = (i == 0) ? 12'h400 : ((i == 2) ? 12'h004 : 12'h000);
            drive(1'b0, (i == 0) ? 12'h004 : 12'h000, h, (i < 2) ? 8'h33 : 8'h48,
                  ex((i == 1 || i == 2) ? 12'h004 : 12'h000,
                     (i == 1 || i == 2) ? 12'h400 : 12'h000,
                     (i >= 2 && i <= 14) ? 2'b11 : 2'b00,
                     (i >= 3 && i <= 10) ? 2'b11 : 2'b00));
            exp_v = sb_q.pop_front();
            got   = {dest_o, req_o, hold_o, door_o};
            n_tests++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL both_elev c%0d: got %h expected %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_sequence();
        logic [27:0] exp_v;
        logic [27:0] got;
        logic [27:0] tbl [6];
        tbl[0] = ex(12'h000, 12'h000, 2'b00, 2'b00);
        tbl[1] = ex(12'h002, 12'h080, 2'b10, 2'b00);
        tbl[2] = ex(12'h000, 12'h080, 2'b10, 2'b10);
        tbl[3] = ex(12'h020, 12'h080, 2'b10, 2'b10);
        tbl[4] = ex(12'h000, 12'h000, 2'b00, 2'b00);
        tbl[5] = ex(12'h000, 12'h000, 2'b00, 2'b00);
        for (int i = 0; i < 6; i++) begin
            drive((i == 3), (i == 0) ? 12'h002 : ((i == 2) ? 12'h020 : 12'h000),
                  (i == 0) ? 12'h080 : 12'h000, 8'h23, tbl[i]);
            exp_v = sb_q.pop_front();
            got   = {dest_o, req_o, hold_o, door_o};
            n_tests++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL reset_mid c%0d: got %h expected %h", i, got, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cab_left();
        test_hall_right();
        test_press_during_open();
        test_press_during_close();
        test_both_and_same_cycle_press();
        test_reset_mid_sequence();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
